// File: rtl/pe_operand_feeder.sv
// Buffers an NxN A (row-major) and B (column-major) matrix and streams them with diagonal skew into the PE mesh edges.
// Optional sticky err flag for requests made while busy: define FEEDER_ERR_EN.
module pe_operand_feeder #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic                wr_sel_i,
  input  logic [ADDR_W-1:0]   wr_row_i,
  input  logic [ADDR_W-1:0]   wr_col_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                acc_clr_o,
  output logic [N*DATA_W-1:0] a_edge_o,
  output logic [N*DATA_W-1:0] b_edge_o,
  output logic                done_o
`ifdef FEEDER_ERR_EN
  ,
  output logic                err_o,
  input  logic                err_clr_i
`endif
);

  localparam int CNT_W = $clog2(2 * N);
  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(2 * N - 2);
  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(N - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_CLR, ST_STREAM, ST_FLUSH, ST_DONE} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q, acc_clr_q, done_q;
  logic [N*DATA_W-1:0] a_edge_q, b_edge_q;
  logic [N*DATA_W-1:0] a_edge_d, b_edge_d;
  logic [CNT_W-1:0]    k_d;

  logic [DATA_W-1:0] a_mem_q [N][N];
  logic [DATA_W-1:0] b_mem_q [N][N];

  always_ff @(posedge clk_i) begin
    if (wr_en_i && state_q == ST_IDLE) begin
      if (wr_sel_i) b_mem_q[wr_row_i][wr_col_i] <= wr_data_i;
      else          a_mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  // Edges are registered, so they are built from the stream index of the coming cycle.
  assign k_d = (state_q == ST_CLR) ? '0 : cnt_q + 1'b1;

  for (genvar gi = 0; gi < N; gi++) begin : g_edge
    logic [CNT_W-1:0] off;
    logic             hit;
    assign off = k_d - CNT_W'(gi);
    assign hit = (k_d >= CNT_W'(gi)) && (off < CNT_W'(N));
    assign a_edge_d[gi*DATA_W +: DATA_W] = hit ? a_mem_q[gi][off[ADDR_W-1:0]] : '0;
    assign b_edge_d[gi*DATA_W +: DATA_W] = hit ? b_mem_q[off[ADDR_W-1:0]][gi] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      a_edge_q  <= '0;
      b_edge_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q   <= ST_CLR;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            acc_clr_q <= 1'b1;
          end
        end
        ST_CLR: begin
          state_q   <= ST_STREAM;
          cnt_q     <= '0;
          acc_clr_q <= 1'b0;
          a_edge_q  <= a_edge_d;
          b_edge_q  <= b_edge_d;
        end
        ST_STREAM: begin
          if (cnt_q == STREAM_LAST) begin
            state_q  <= ST_FLUSH;
            cnt_q    <= '0;
            a_edge_q <= '0;
            b_edge_q <= '0;
          end else begin
            cnt_q    <= k_d;
            a_edge_q <= a_edge_d;
            b_edge_q <= b_edge_d;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          busy_q    <= 1'b0;
          acc_clr_q <= 1'b0;
          done_q    <= 1'b0;
          a_edge_q  <= '0;
          b_edge_q  <= '0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign acc_clr_o = acc_clr_q;
  assign done_o    = done_q;
  assign a_edge_o  = a_edge_q;
  assign b_edge_o  = b_edge_q;

`ifdef FEEDER_ERR_EN
  logic err_q;
  // A new error outranks a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         err_q <= 1'b0;
    else if (busy_q && (wr_en_i || start_i)) err_q <= 1'b1;
    else if (err_clr_i)                  err_q <= 1'b0;
  end
  assign err_o = err_q;
`endif

endmodule
